// File: rtl/pipe_pkg.sv
// Shared types for the pipeline tracker: the instruction slot record and its bubble value.
package pipe_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int REG_AW_DEFAULT = 5;

    typedef struct packed {
        logic                      valid;
        logic [XLEN_DEFAULT-1:0]   instr;
        logic [XLEN_DEFAULT-1:0]   pc;
        logic [REG_AW_DEFAULT-1:0] rd;
        logic                      rd_used;
        logic                      mem_used;
    } slot_t;

    localparam slot_t BUBBLE = '0;

endpackage

// File: rtl/pipe_slot_reg.sv
// One pipeline slot register: flush beats enable, enable selects load vs hold, nop loads a bubble.
module pipe_slot_reg
    import pipe_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  ena,
    input  logic  nop,
    input  logic  flush,
    input  slot_t d,
    output slot_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BUBBLE;
        end else if (flush) begin
            q <= BUBBLE;
        end else if (ena) begin
            q <= nop ? BUBBLE : d;
        end
    end

endmodule

// File: rtl/pipeline_tracker.sv
// DEC/OP/EX/WB slot registers under hazard-unit control, with rd feedback for hazard detection.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_tracker #(
    parameter int XLEN   = pipe_pkg::XLEN_DEFAULT,
    parameter int REG_AW = pipe_pkg::REG_AW_DEFAULT,
    parameter int PCNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_valid,
    input  logic [XLEN-1:0]   fetch_instr,
    input  logic [XLEN-1:0]   fetch_pc,
    input  logic              fetch_ena,
    input  logic              dec_ena,
    input  logic              op_ena,
    input  logic              ex_ena,
    input  logic              wb_ena,
    input  logic              mem_ena,
    input  logic              fetch_nop,
    input  logic              dec_nop,
    input  logic              op_nop,
    input  logic              ex_nop,
    input  logic              wb_nop,
    input  logic              mem_nop,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_rd_used,
    input  logic              dec_mem_used,
    input  logic              flush,
    output logic              dec_valid,
    output logic [XLEN-1:0]   dec_instr,
    output logic [XLEN-1:0]   dec_pc,
    output logic              fetch_hold,
    output logic [REG_AW-1:0] rd_op,
    output logic              rd_used_op,
    output logic [REG_AW-1:0] rd_ex,
    output logic              rd_used_ex,
    output logic              mem_req,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_we,
    output logic [PCNT_W-1:0] stall_cnt,
    output logic [PCNT_W-1:0] bubble_cnt
);
    import pipe_pkg::*;

    slot_t fetch_slot, dec_slot, dec_fwd, op_slot, ex_slot, wb_slot;
    logic  unused_ok;

    always_comb begin
        fetch_slot       = BUBBLE;
        fetch_slot.valid = fetch_valid;
        fetch_slot.instr = fetch_instr;
        fetch_slot.pc    = fetch_pc;
    end

    // DEC has no decoded fields of its own; the combinational decoder supplies them on the way to OP.
    always_comb begin
        dec_fwd          = dec_slot;
        dec_fwd.rd       = dec_rd;
        dec_fwd.rd_used  = dec_rd_used;
        dec_fwd.mem_used = dec_mem_used;
    end

    pipe_slot_reg u_dec (.clk(clk), .rst_n(rst_n), .ena(dec_ena), .nop(fetch_nop),
                         .flush(flush), .d(fetch_slot), .q(dec_slot));
    pipe_slot_reg u_op  (.clk(clk), .rst_n(rst_n), .ena(op_ena),  .nop(dec_nop),
                         .flush(flush), .d(dec_fwd),    .q(op_slot));
    pipe_slot_reg u_ex  (.clk(clk), .rst_n(rst_n), .ena(ex_ena),  .nop(op_nop),
                         .flush(1'b0),  .d(op_slot),    .q(ex_slot));
    pipe_slot_reg u_wb  (.clk(clk), .rst_n(rst_n), .ena(wb_ena),  .nop(ex_nop),
                         .flush(1'b0),  .d(ex_slot),    .q(wb_slot));

    assign dec_valid  = dec_slot.valid;
    assign dec_instr  = dec_slot.instr;
    assign dec_pc     = dec_slot.pc;
    assign fetch_hold = ~fetch_ena;

    assign rd_op      = op_slot.rd;
    assign rd_used_op = op_slot.valid & op_slot.rd_used;
    assign rd_ex      = ex_slot.rd;
    assign rd_used_ex = ex_slot.valid & ex_slot.rd_used;
    assign mem_req    = ex_slot.valid & ex_slot.mem_used & mem_ena & ~mem_nop;

    // x0 writes are architecturally discarded, so they never reach the register file.
    assign wb_rd      = wb_slot.rd;
    assign wb_we      = wb_slot.valid & wb_slot.rd_used & (wb_slot.rd != '0);

    assign unused_ok  = ^{dec_slot.rd, dec_slot.rd_used, dec_slot.mem_used,
                          wb_slot.instr, wb_slot.pc, wb_slot.mem_used, wb_nop};

`ifdef PIPE_PERF_CNT_EN
    logic [PCNT_W-1:0] stall_q, bubble_q;
    logic              bubble_evt;

    assign bubble_evt = (dec_nop & op_ena) | (op_nop & ex_ena);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (!fetch_ena && (stall_q != '1)) begin
                stall_q <= stall_q + PCNT_W'(1);
            end
            if (bubble_evt && (bubble_q != '1)) begin
                bubble_q <= bubble_q + PCNT_W'(1);
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_tracker.sv
// Scoreboard bench for pipeline_tracker: expected WB results are queued at fetch and matched by due cycle.
module tb_pipeline_tracker;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int PCNT_W = 4;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_valid;
    logic [XLEN-1:0]   fetch_instr, fetch_pc;
    logic              fetch_ena, dec_ena, op_ena, ex_ena, wb_ena, mem_ena;
    logic              fetch_nop, dec_nop, op_nop, ex_nop, wb_nop, mem_nop;
    logic [REG_AW-1:0] dec_rd;
    logic              dec_rd_used, dec_mem_used, flush;
    logic              dec_valid;
    logic [XLEN-1:0]   dec_instr, dec_pc;
    logic              fetch_hold;
    logic [REG_AW-1:0] rd_op, rd_ex, wb_rd;
    logic              rd_used_op, rd_used_ex, mem_req, wb_we;
    logic [PCNT_W-1:0] stall_cnt, bubble_cnt;

    logic drv_fetch_ena, drv_dec_ena, drv_dec_nop, hz_en, hz;
    logic [REG_AW-1:0] rs1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int              due;
        logic [REG_AW-1:0] rd;
        logic            we;
    } exp_t;
    exp_t sb[$];

    pipeline_tracker #(.XLEN(XLEN), .REG_AW(REG_AW), .PCNT_W(PCNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .fetch_pc(fetch_pc), .fetch_ena(fetch_ena), .dec_ena(dec_ena), .op_ena(op_ena),
        .ex_ena(ex_ena), .wb_ena(wb_ena), .mem_ena(mem_ena), .fetch_nop(fetch_nop),
        .dec_nop(dec_nop), .op_nop(op_nop), .ex_nop(ex_nop), .wb_nop(wb_nop),
        .mem_nop(mem_nop), .dec_rd(dec_rd), .dec_rd_used(dec_rd_used),
        .dec_mem_used(dec_mem_used), .flush(flush), .dec_valid(dec_valid),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .fetch_hold(fetch_hold), .rd_op(rd_op),
        .rd_used_op(rd_used_op), .rd_ex(rd_ex), .rd_used_ex(rd_used_ex), .mem_req(mem_req),
        .wb_rd(wb_rd), .wb_we(wb_we), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Toy decoder: rd=[11:7], writes rd=[12], memory access=[13], rs1=[19:15].
    assign dec_rd       = dec_instr[11:7];
    assign dec_rd_used  = dec_instr[12];
    assign dec_mem_used = dec_instr[13];
    assign rs1          = dec_instr[19:15];

    // Minimal hazard unit: hold fetch/DEC and bubble OP while a producer of rs1 sits in OP or EX.
    assign hz = hz_en & dec_valid & (rs1 != '0) &
                ((rd_used_op & (rd_op == rs1)) | (rd_used_ex & (rd_ex == rs1)));
    assign fetch_ena = drv_fetch_ena & ~hz;
    assign dec_ena   = drv_dec_ena & ~hz;
    assign dec_nop   = drv_dec_nop | hz;

    function automatic logic [XLEN-1:0] mk(input logic [4:0] rd, input logic used,
                                           input logic mem, input logic [4:0] src);
        return {12'd0, src, 1'b0, mem, used, rd, 7'h13};
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic sb_check();
        if (sb.size() > 0 && sb[0].due == cyc) begin
            chk("wb_rd", 64'(wb_rd), 64'(sb[0].rd));
            chk("wb_we", 64'(wb_we), 64'(sb[0].we));
            void'(sb.pop_front());
        end else begin
            chk("wb_idle", 64'({wb_rd, wb_we}), 64'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        sb_check();
    endtask

    task automatic issue(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                         input int extra, input bit track);
        exp_t e;
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_instr = ins;
        if (track) begin
            e.due = cyc + 4 + extra;
            e.rd  = ins[11:7];
            e.we  = ins[12] && (ins[11:7] != 5'd0);
            sb.push_back(e);
        end
    endtask

    task automatic idle_fetch();
        fetch_valid = 1'b0;
        fetch_pc    = '0;
        fetch_instr = '0;
    endtask

    task automatic defaults();
        drv_fetch_ena = 1'b1; drv_dec_ena = 1'b1; op_ena = 1'b1; ex_ena = 1'b1;
        wb_ena = 1'b1; mem_ena = 1'b1; fetch_nop = 1'b0; drv_dec_nop = 1'b0;
        op_nop = 1'b0; ex_nop = 1'b0; wb_nop = 1'b0; mem_nop = 1'b0; flush = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dec_valid"}, 64'(dec_valid), 64'd0);
        chk({tag, "_dec_instr"}, 64'(dec_instr), 64'd0);
        chk({tag, "_dec_pc"},    64'(dec_pc),    64'd0);
        chk({tag, "_rd_op"},     64'({rd_op, rd_used_op}), 64'd0);
        chk({tag, "_rd_ex"},     64'({rd_ex, rd_used_ex}), 64'd0);
        chk({tag, "_wb"},        64'({wb_rd, wb_we}), 64'd0);
        chk({tag, "_mem_req"},   64'(mem_req), 64'd0);
    endtask

    initial begin
        defaults();
        hz_en = 1'b0;
        idle_fetch();
        rst_n = 1'b0;
        repeat (2) tick();
        chk_all_zero("reset");
        chk("reset_cnt", 64'({stall_cnt, bubble_cnt}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Six independent instructions back to back.
        for (int i = 0; i < 6; i++) begin
            issue(32'h100 + 32'(4 * i), mk(5'(i + 1), 1'b0, 1'b0, 5'd0), 0, 1'b1);
            chk("no_hold", 64'(fetch_hold), 64'd0);
            tick();
            chk("dec_pc_seq", 64'(dec_pc), 64'(32'h100 + 32'(4 * i)));
        end
        idle_fetch();
        repeat (5) tick();

        // Memory instruction: mem_req while in EX, masked by mem_nop.
        issue(32'h180, mk(5'd7, 1'b1, 1'b1, 5'd0), 0, 1'b1);
        tick();
        idle_fetch();
        chk("dec_valid", 64'(dec_valid), 64'd1);
        tick();
        chk("op_rd", 64'({rd_op, rd_used_op}), 64'({5'd7, 1'b1}));
        tick();
        chk("ex_rd", 64'({rd_ex, rd_used_ex}), 64'({5'd7, 1'b1}));
        chk("mem_req", 64'(mem_req), 64'd1);
        mem_nop = 1'b1;
        #1;
        chk("mem_req_nop", 64'(mem_req), 64'd0);
        mem_nop = 1'b0;
        repeat (3) tick();

        // RAW hazard with the bench hazard unit in the loop: consumer lands two cycles late.
        hz_en = 1'b1;
        issue(32'h200, mk(5'd5, 1'b1, 1'b0, 5'd0), 0, 1'b1);
        tick();
        issue(32'h204, mk(5'd6, 1'b1, 1'b0, 5'd5), 2, 1'b1);
        tick();
        idle_fetch();
        chk("hz_op_hold", 64'(fetch_hold), 64'd1);
        tick();
        chk("hz_dec_keep", 64'(dec_pc), 64'h204);
        chk("hz_op_bubble", 64'(rd_used_op), 64'd0);
        chk("hz_ex_prod", 64'({rd_ex, rd_used_ex}), 64'({5'd5, 1'b1}));
        chk("hz_ex_hold", 64'(fetch_hold), 64'd1);
        tick();
        chk("hz_ex_bubble", 64'(rd_used_ex), 64'd0);
        chk("hz_release", 64'(fetch_hold), 64'd0);
        repeat (4) tick();

        // x0 producer: visible to the hazard port, never written back, never stalls.
        issue(32'h300, mk(5'd0, 1'b1, 1'b0, 5'd0), 0, 1'b1);
        tick();
        issue(32'h304, mk(5'd3, 1'b1, 1'b0, 5'd0), 0, 1'b1);
        tick();
        idle_fetch();
        chk("x0_used_op", 64'({rd_op, rd_used_op}), 64'({5'd0, 1'b1}));
        chk("x0_no_hold", 64'(fetch_hold), 64'd0);
        repeat (4) tick();
        hz_en = 1'b0;

        // EX-hazard pattern: OP holds, EX receives a bubble.
        issue(32'h400, mk(5'd9, 1'b1, 1'b0, 5'd0), 1, 1'b1);
        tick();
        issue(32'h404, mk(5'd10, 1'b1, 1'b0, 5'd0), 1, 1'b1);
        tick();
        idle_fetch();
        drv_fetch_ena = 1'b0; drv_dec_ena = 1'b0; op_ena = 1'b0; op_nop = 1'b1;
        tick();
        defaults();
        chk("exh_op_hold", 64'({rd_op, rd_used_op}), 64'({5'd9, 1'b1}));
        chk("exh_ex_bubble", 64'(rd_used_ex), 64'd0);
        chk("exh_dec_hold", 64'(dec_pc), 64'h404);
        repeat (5) tick();

        // Flush during a DEC stall: DEC/OP die, EX/WB keep advancing.
        issue(32'h500, mk(5'd11, 1'b1, 1'b0, 5'd0), 0, 1'b1);
        tick();
        issue(32'h504, mk(5'd12, 1'b1, 1'b0, 5'd0), 0, 1'b1);
        tick();
        issue(32'h508, mk(5'd13, 1'b1, 1'b0, 5'd0), 0, 1'b0);
        tick();
        idle_fetch();
        drv_fetch_ena = 1'b0; drv_dec_ena = 1'b0; flush = 1'b1;
        tick();
        defaults();
        chk("flush_dec", 64'({dec_valid, dec_pc}), 64'd0);
        chk("flush_op", 64'(rd_used_op), 64'd0);
        chk("flush_ex_adv", 64'({rd_ex, rd_used_ex}), 64'({5'd12, 1'b1}));
        repeat (4) tick();

        // Reset in the middle of a stall with three live slots.
        issue(32'h600, mk(5'd14, 1'b1, 1'b1, 5'd0), 0, 1'b0);
        tick();
        issue(32'h604, mk(5'd15, 1'b1, 1'b0, 5'd0), 0, 1'b0);
        tick();
        issue(32'h608, mk(5'd16, 1'b1, 1'b0, 5'd0), 0, 1'b0);
        tick();
        idle_fetch();
        drv_fetch_ena = 1'b0; drv_dec_ena = 1'b0; op_ena = 1'b0; ex_ena = 1'b0; ex_nop = 1'b1;
        tick();
        chk("stall_live", 64'({dec_valid, rd_used_op, rd_used_ex}), 64'b111);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst_n = 1'b1;
        defaults();
        repeat (5) tick();
        issue(32'h700, mk(5'd17, 1'b1, 1'b0, 5'd0), 0, 1'b1);
        tick();
        idle_fetch();
        chk("resume_dec", 64'(dec_pc), 64'h700);
        repeat (4) tick();

        // fetch_nop turns a presented fetch into a DEC bubble.
        issue(32'h800, mk(5'd18, 1'b1, 1'b0, 5'd0), 0, 1'b0);
        fetch_nop = 1'b1;
        tick();
        idle_fetch();
        fetch_nop = 1'b0;
        chk("fetch_nop", 64'(dec_valid), 64'd0);

        // Performance counters (tied to zero when the feature is absent).
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("cnt_reset", 64'({stall_cnt, bubble_cnt}), 64'd0);
        drv_fetch_ena = 1'b0;
        repeat (3) tick();
        drv_fetch_ena = 1'b1;
        chk("stall_cnt3", 64'(stall_cnt), PERF ? 64'd3 : 64'd0);
        chk("bubble_cnt0", 64'(bubble_cnt), 64'd0);
        drv_dec_nop = 1'b1;
        tick();
        drv_dec_nop = 1'b0;
        chk("bubble_cnt1", 64'(bubble_cnt), PERF ? 64'd1 : 64'd0);
        drv_fetch_ena = 1'b0;
        repeat (20) tick();
        drv_fetch_ena = 1'b1;
        chk("stall_sat", 64'(stall_cnt), PERF ? 64'hF : 64'd0);
        tick();
        chk("stall_sat_hold", 64'(stall_cnt), PERF ? 64'hF : 64'd0);

        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
